nor_bus_mcs: RTL and testbench
==============================

NOR_BUS_MCS -- requirements
Module: nor_bus_mcs

Interface
REQ-001 SHALL have parameter ADDRBITS, default 24: NOR word-address width per chip.
REQ-002 SHALL have parameter DATABITS, default 16: NOR data width.
REQ-003 SHALL have parameter NCHIPS, default 4: number of NOR devices, CSBITS = max(1, clog2(NCHIPS)).
REQ-004 SHALL have parameter PGLOG2, default 3: log2 of page size in words.
REQ-005 SHALL have parameter QDEPTH, default 4: request FIFO depth, a power of 2 and at least 2.
REQ-006 SHALL have parameter CNTBITS, default 8: wait-counter width.
REQ-007 SHALL have ports sys_clk_i in 1 (clock) and sys_rst_i in 1 (reset); one clock, and reset is asynchronous and active-high.
REQ-008 SHALL have request ports: req_stb_i in 1; req_we_i in 1; req_adr_i in CSBITS+ADDRBITS ({chip, word}); req_dat_i in DATABITS; req_stall_o out 1.
REQ-009 SHALL have response ports: ack_o out 1; err_o out 1, valid with ack_o; dat_o out DATABITS.
REQ-010 SHALL have config ports: pgen_i in 1; wait_write_i, wait_readdly_i, wait_read_i, wait_readpg_i, ry_timeout_i, each in CNTBITS.
REQ-011 SHALL have NOR ports: nor_ry_i in 1; nor_data_i in DATABITS; nor_data_o out DATABITS; nor_addr_o out ADDRBITS; nor_ce_o out NCHIPS (one-hot, active-low); nor_we_o out 1 (active-low); nor_oe_o out 1 (active-low); nor_data_oe out 1 (1 = drive).

Function
REQ-012 SHALL push {we, dat, adr} into the FIFO when req_stb_i=1 and req_stall_o=0; req_stall_o = FIFO full; a strobe while stalled is dropped.
REQ-013 SHALL use FSM states IDLE, WRITE, RYWAIT, READDLY, READ, READPG, TXN_END.
REQ-014 SHALL hold each timed state for wait+1 cycles (WRITE: wait_write_i; READDLY: wait_readdly_i; READ: wait_read_i; READPG: wait_readpg_i; TXN_END: 1 cycle).
REQ-015 SHALL transition IDLE->WRITE or IDLE->READDLY on a non-empty FIFO, WRITE->RYWAIT, READDLY->READ, RYWAIT->TXN_END, TXN_END->IDLE.
REQ-016 SHALL leave READ/READPG for READPG when the next entry is a read to the same chip and same page (word>>PGLOG2) with pgen_i=1, for READ when it is a read to the same chip otherwise, and for TXN_END in all other cases (a write, a different chip, or an empty FIFO).
REQ-017 SHALL pass nor_ry_i through a 2-flop synchroniser, and SHALL leave RYWAIT when the counter is at least 2 and the synchronised RY is 1, or when the counter equals ry_timeout_i, whichever comes first.
REQ-018 SHALL pulse ack_o for one cycle on the last cycle of READ, READPG and RYWAIT, and SHALL pop the FIFO on that cycle.
REQ-019 SHALL drive err_o=1 with a write ack when RYWAIT exits on timeout, and 0 otherwise.
REQ-020 SHALL, for a read, load dat_o with nor_data_i sampled on the ack cycle; dat_o SHALL equal 0 on a write ack.
REQ-021 SHALL register all NOR and response outputs, so each lags the FSM state by one cycle.
REQ-022 SHALL drive nor_ce_o[chip] low in every state except IDLE and TXN_END.
REQ-023 SHALL drive nor_we_o low only in WRITE.
REQ-024 SHALL drive nor_oe_o low in READDLY, READ and READPG.
REQ-025 SHALL drive nor_data_oe = 1 only in WRITE and RYWAIT.
REQ-026 SHALL, for a chip index >= NCHIPS, assert no CE, ack with err_o=1 in the cycle after dequeue, and pop the entry.
REQ-027 SHALL sample the config inputs live; software keeps them stable while any transaction is queued or active.

Reset
REQ-028 SHALL, while sys_rst_i=1, immediately force: FSM=IDLE, FIFO empty, counter 0, nor_ce_o all ones, nor_we_o=1, nor_oe_o=1, nor_data_oe=0, nor_addr_o=0, nor_data_o=0, ack_o=0, err_o=0, dat_o=0, req_stall_o=0.
REQ-029 SHALL drop an in-flight transaction that is aborted by reset, with no ack for it.

Structure
REQ-030 SHALL put the state encoding and the request-packing widths in a shared package, nor_bus_pkg.
REQ-031 SHALL place the FIFO in a single sub-module, nor_req_fifo, parametrised by WIDTH and DEPTH.

Verification
REQ-032 SHALL cover a single write: wait_write=3, RY low for 10 cycles -> WE low 4 cycles, ack 1, err 0, CE[chip] high after TXN_END.
REQ-033 SHALL cover a write timeout: ry_timeout=20, RY held low -> ack with err_o=1 exactly 20 cycles after RYWAIT entry.
REQ-034 SHALL cover a page burst: 4 reads at 0x10-0x13, chip 1, pgen=1 -> one READDLY, then READ + 3 READPG, CE_n[1] low throughout, 4 acks with the correct data.
REQ-035 SHALL cover a chip switch: reads to chip 0 then chip 2 -> TXN_END between the two, and no CE overlap.
REQ-036 SHALL cover backpressure: 5 strobes with QDEPTH=4 and the NOR busy -> 5th strobe sees stall=1 and is dropped; exactly 4 acks.
REQ-037 SHALL cover reset mid-READ -> all outputs at reset values asynchronously, and no ack afterwards.

Source files
------------

// File: rtl/nor_bus_pkg.sv
// Shared definitions for the NOR bus controller: FSM encoding and the
// helpers that size the packed request word {we, dat, adr}.
package nor_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RYWAIT  = 3'd2,
    READDLY = 3'd3,
    READ    = 3'd4,
    READPG  = 3'd5,
    TXN_END = 3'd6
  } nor_state_e;

  localparam int REQ_WE_BITS = 1;

  // Chip-select index width; never narrower than one bit.
  function automatic int cs_bits(input int nchips);
    return (nchips > 1) ? $clog2(nchips) : 1;
  endfunction

  // Width of one queued request {we, dat, chip, word}.
  function automatic int req_width(input int addrbits, input int databits, input int csbits);
    return REQ_WE_BITS + databits + csbits + addrbits;
  endfunction

endpackage

// File: rtl/nor_req_fifo.sv
// Request FIFO with look-ahead: exposes the head entry and the one behind it
// so the controller can decide on page/chip continuation before popping.
module nor_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + PW'(1)];

  // Next pointer/occupancy values; overflow and underflow requests are ignored.
  always_comb begin
    push_ok_s = push_i && !full_o;
    pop_ok_s  = pop_i && !empty_o;
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_ok_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so no stale request can ever be seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/nor_bus_mcs.sv
// Multi-chip NOR flash bus controller: queues requests, runs timed NOR
// read/write cycles with page-mode bursts and RY/BY polling, registered pins.
module nor_bus_mcs
  import nor_bus_pkg::*;
#(
  parameter int ADDRBITS = 24,
  parameter int DATABITS = 16,
  parameter int NCHIPS   = 4,
  parameter int PGLOG2   = 3,
  parameter int QDEPTH   = 4,
  parameter int CNTBITS  = 8
) (
  input  logic                                 sys_clk_i,
  input  logic                                 sys_rst_i,
  input  logic                                 req_stb_i,
  input  logic                                 req_we_i,
  input  logic [cs_bits(NCHIPS)+ADDRBITS-1:0]  req_adr_i,
  input  logic [DATABITS-1:0]                  req_dat_i,
  output logic                                 req_stall_o,
  output logic                                 ack_o,
  output logic                                 err_o,
  output logic [DATABITS-1:0]                  dat_o,
  input  logic                                 pgen_i,
  input  logic [CNTBITS-1:0]                   wait_write_i,
  input  logic [CNTBITS-1:0]                   wait_readdly_i,
  input  logic [CNTBITS-1:0]                   wait_read_i,
  input  logic [CNTBITS-1:0]                   wait_readpg_i,
  input  logic [CNTBITS-1:0]                   ry_timeout_i,
  input  logic                                 nor_ry_i,
  input  logic [DATABITS-1:0]                  nor_data_i,
  output logic [DATABITS-1:0]                  nor_data_o,
  output logic [ADDRBITS-1:0]                  nor_addr_o,
  output logic [NCHIPS-1:0]                    nor_ce_o,
  output logic                                 nor_we_o,
  output logic                                 nor_oe_o,
  output logic                                 nor_data_oe
);

  localparam int CSBITS = cs_bits(NCHIPS);
  localparam int AW     = CSBITS + ADDRBITS;
  localparam int REQW   = req_width(ADDRBITS, DATABITS, CSBITS);
  localparam int QPW    = $clog2(QDEPTH);
  localparam logic [CSBITS:0] NCHIPS_L = (CSBITS+1)'(NCHIPS);

  nor_state_e          state_q, state_d;
  logic [CNTBITS-1:0]  cnt_q, cnt_d;
  logic                ry_meta_q, ry_sync_q;
  logic                pop_s, fifo_full_s, fifo_empty_s;
  logic [QPW:0]        fifo_count_s;
  logic [REQW-1:0]     head_s, next_s;
  logic                head_we_s, next_we_s, next_valid_s, head_chip_ok_s;
  logic [DATABITS-1:0] head_dat_s;
  logic [CSBITS-1:0]   head_chip_s, next_chip_s;
  logic [ADDRBITS-1:0] head_word_s, next_word_s;
  logic                same_page_s, ry_ok_s, ry_tmo_s, active_s;
  logic                unused_next_dat_s;

  logic                ack_q, ack_d, err_q, err_d;
  logic [DATABITS-1:0] dat_q, dat_d, nor_data_q, nor_data_d;
  logic [ADDRBITS-1:0] nor_addr_q, nor_addr_d;
  logic [NCHIPS-1:0]   nor_ce_q, nor_ce_d;
  logic                nor_we_q, nor_we_d, nor_oe_q, nor_oe_d, nor_doe_q, nor_doe_d;

  nor_req_fifo #(.WIDTH(REQW), .DEPTH(QDEPTH)) u_fifo (
    .clk         (sys_clk_i),
    .rst         (sys_rst_i),
    .push_i      (req_stb_i),
    .push_data_i ({req_we_i, req_dat_i, req_adr_i}),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .next_o      (next_s),
    .count_o     (fifo_count_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign req_stall_o       = fifo_full_s;
  assign head_we_s         = head_s[REQW-1];
  assign head_dat_s        = head_s[REQW-2 -: DATABITS];
  assign head_chip_s       = head_s[AW-1 -: CSBITS];
  assign head_word_s       = head_s[ADDRBITS-1:0];
  assign next_we_s         = next_s[REQW-1];
  assign next_chip_s       = next_s[AW-1 -: CSBITS];
  assign next_word_s       = next_s[ADDRBITS-1:0];
  assign unused_next_dat_s = ^next_s[REQW-2 -: DATABITS];
  assign next_valid_s      = (fifo_count_s > (QPW+1)'(1));
  assign head_chip_ok_s    = ({1'b0, head_chip_s} < NCHIPS_L);
  assign same_page_s       = ((head_word_s >> PGLOG2) == (next_word_s >> PGLOG2));
  assign ry_ok_s           = (cnt_q >= CNTBITS'(2)) && ry_sync_q;
  assign ry_tmo_s          = (cnt_q == ry_timeout_i);

  // Two-flop synchroniser for the asynchronous RY/BY pin.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      ry_meta_q <= 1'b0;
      ry_sync_q <= 1'b0;
    end else begin
      ry_meta_q <= nor_ry_i;
      ry_sync_q <= ry_meta_q;
    end
  end

  // Next-state, wait counter, FIFO pop and response generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_s   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fifo_empty_s) begin
          state_d = IDLE;
        end else if (!head_chip_ok_s) begin
          // No device behind this chip index: drop it with an error ack.
          pop_s = 1'b1;
          ack_d = 1'b1;
          err_d = 1'b1;
          dat_d = '0;
        end else if (head_we_s) begin
          state_d = WRITE;
        end else begin
          state_d = READDLY;
        end
      end
      WRITE: begin
        if (cnt_q == wait_write_i) begin
          state_d = RYWAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTBITS'(1);
        end
      end
      RYWAIT: begin
        if (ry_ok_s || ry_tmo_s) begin
          pop_s   = 1'b1;
          ack_d   = 1'b1;
          err_d   = !ry_ok_s;
          dat_d   = '0;
          state_d = TXN_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTBITS'(1);
        end
      end
      READDLY: begin
        if (cnt_q == wait_readdly_i) begin
          state_d = READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTBITS'(1);
        end
      end
      READ, READPG: begin
        if (cnt_q == ((state_q == READ) ? wait_read_i : wait_readpg_i)) begin
          pop_s = 1'b1;
          ack_d = 1'b1;
          dat_d = nor_data_i;
          cnt_d = '0;
          // Stay selected only for a following read on the same chip.
          if (next_valid_s && !next_we_s && (next_chip_s == head_chip_s)) begin
            state_d = (pgen_i && same_page_s) ? READPG : READ;
          end else begin
            state_d = TXN_END;
          end
        end else begin
          cnt_d = cnt_q + CNTBITS'(1);
        end
      end
      TXN_END: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pin values decoded from the current state; they appear one cycle later.
  always_comb begin
    active_s  = (state_q != IDLE) && (state_q != TXN_END);
    nor_we_d  = (state_q != WRITE);
    nor_oe_d  = !((state_q == READDLY) || (state_q == READ) || (state_q == READPG));
    nor_doe_d = (state_q == WRITE) || (state_q == RYWAIT);
    nor_ce_d  = '1;
    for (int i = 0; i < NCHIPS; i++) begin
      if (active_s && (head_chip_s == CSBITS'(i))) begin
        nor_ce_d[i] = 1'b0;
      end else begin
        nor_ce_d[i] = 1'b1;
      end
    end
    if (active_s) begin
      nor_addr_d = head_word_s;
    end else begin
      nor_addr_d = nor_addr_q;
    end
    if (nor_doe_d) begin
      nor_data_d = head_dat_s;
    end else begin
      nor_data_d = nor_data_q;
    end
  end

  // Registered NOR pins and response outputs.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      nor_ce_q   <= '1;
      nor_we_q   <= 1'b1;
      nor_oe_q   <= 1'b1;
      nor_doe_q  <= 1'b0;
      nor_addr_q <= '0;
      nor_data_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      nor_ce_q   <= nor_ce_d;
      nor_we_q   <= nor_we_d;
      nor_oe_q   <= nor_oe_d;
      nor_doe_q  <= nor_doe_d;
      nor_addr_q <= nor_addr_d;
      nor_data_q <= nor_data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign nor_ce_o    = nor_ce_q;
  assign nor_we_o    = nor_we_q;
  assign nor_oe_o    = nor_oe_q;
  assign nor_data_oe = nor_doe_q;
  assign nor_addr_o  = nor_addr_q;
  assign nor_data_o  = nor_data_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign dat_o       = dat_q;

endmodule

// File: tb/tb_nor_bus_mcs.sv
// Directed testbench for nor_bus_mcs: a pin monitor gathers events, and each
// scenario task compares what it gathered against hand-computed values.
module tb_nor_bus_mcs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_stb = 1'b0, req_we = 1'b0;
  logic [25:0] req_adr = '0;
  logic [15:0] req_dat = '0;
  logic        req_stall, ack, err;
  logic [15:0] dat_o;
  logic        pgen = 1'b0;
  logic [7:0]  w_write = 8'd3, w_readdly = 8'd2, w_read = 8'd2, w_readpg = 8'd1, ry_tmo = 8'd50;
  logic        ry = 1'b1;
  logic [15:0] nor_din, nor_dout;
  logic [23:0] nor_addr;
  logic [3:0]  ce;
  logic        we_n, oe_n, data_oe;

  int tests = 0;
  int failed = 0;

  // Memory model: read data is a fixed function of the address pins.
  assign nor_din = nor_addr[15:0] ^ 16'h5A5A;

  always #5 clk = ~clk;

  nor_bus_mcs dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .req_stb_i(req_stb), .req_we_i(req_we), .req_adr_i(req_adr), .req_dat_i(req_dat),
    .req_stall_o(req_stall), .ack_o(ack), .err_o(err), .dat_o(dat_o),
    .pgen_i(pgen), .wait_write_i(w_write), .wait_readdly_i(w_readdly),
    .wait_read_i(w_read), .wait_readpg_i(w_readpg), .ry_timeout_i(ry_tmo),
    .nor_ry_i(ry), .nor_data_i(nor_din), .nor_data_o(nor_dout), .nor_addr_o(nor_addr),
    .nor_ce_o(ce), .nor_we_o(we_n), .nor_oe_o(oe_n), .nor_data_oe(data_oe)
  );

  // Monitor state
  int cyc = 0, ack_cnt, err_cnt, we_low_cnt, we_bad, oe_low_cnt, oe_runs;
  int ce_low_cnt, ce_runs, ce_overlap, ack_cyc, rywait_cyc;
  logic [15:0] ack_dat [$];
  logic [3:0]  ack_ce, ce_after_ack, ce_or;
  logic [3:0]  exp_we_ce = 4'hF;
  logic [15:0] exp_we_dat = '0;
  logic [23:0] exp_we_addr = '0;
  logic prev_ack = 1'b0, prev_we_low = 1'b0, prev_oe_high = 1'b1, prev_ce_high = 1'b1;

  // Pin monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (ack) begin
      ack_cnt++;
      if (err) err_cnt++;
      ack_dat.push_back(dat_o);
      ack_ce  = ce;
      ack_cyc = cyc;
    end
    if (prev_ack) ce_after_ack = ce;
    prev_ack = ack;
    if (!we_n) begin
      we_low_cnt++;
      if (ce !== exp_we_ce || nor_dout !== exp_we_dat || nor_addr !== exp_we_addr || data_oe !== 1'b1) we_bad++;
    end
    if (data_oe && we_n && prev_we_low) rywait_cyc = cyc;
    prev_we_low = !we_n;
    if (!oe_n) begin
      oe_low_cnt++;
      if (prev_oe_high) oe_runs++;
    end
    prev_oe_high = oe_n;
    if (ce != 4'hF) begin
      ce_low_cnt++;
      if (prev_ce_high) ce_runs++;
      ce_or = ce_or | ~ce;
      if ($countones(~ce) > 1) ce_overlap++;
    end
    prev_ce_high = (ce == 4'hF);
  end

  task automatic clear_mon();
    ack_cnt = 0; err_cnt = 0; we_low_cnt = 0; we_bad = 0; oe_low_cnt = 0; oe_runs = 0;
    ce_low_cnt = 0; ce_runs = 0; ce_overlap = 0; ack_cyc = 0; rywait_cyc = 0;
    ack_dat.delete(); ack_ce = 4'h0; ce_after_ack = 4'h0; ce_or = 4'h0;
  endtask

  // Present one request for one cycle; caller drops the strobe afterwards.
  task automatic drive_req(input logic we, input logic [1:0] chip, input logic [23:0] word, input logic [15:0] data);
    req_stb = 1'b1; req_we = we; req_adr = {chip, word}; req_dat = data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++; if ({ce, we_n, oe_n, data_oe} !== 7'b1111_110) begin failed++; $display("FAIL reset_ctl: got %b expected 1111110", {ce, we_n, oe_n, data_oe}); end
    tests++; if ({nor_addr, nor_dout} !== 40'h0) begin failed++; $display("FAIL reset_bus: got %h expected 0", {nor_addr, nor_dout}); end
    tests++; if ({ack, err, dat_o, req_stall} !== 19'h0) begin failed++; $display("FAIL reset_resp: got %h expected 0", {ack, err, dat_o, req_stall}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({ce, ack, req_stall} !== 6'b1111_00) begin failed++; $display("FAIL reset_idle: got %b expected 111100", {ce, ack, req_stall}); end
  endtask

  task automatic test_single_write();
    clear_mon();
    ry = 1'b0; ry_tmo = 8'd50;
    exp_we_ce = 4'b1011; exp_we_dat = 16'hBEEF; exp_we_addr = 24'h000123;
    drive_req(1'b1, 2'd2, 24'h000123, 16'hBEEF);
    req_stb = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c == 9) ry = 1'b1;
      @(negedge clk);
    end
    tests++; if (we_low_cnt !== 4) begin failed++; $display("FAIL wr_we_len: got %0d expected 4", we_low_cnt); end
    tests++; if (we_bad !== 0) begin failed++; $display("FAIL wr_pins: got %0d bad cycles expected 0", we_bad); end
    tests++; if (ack_cnt !== 1 || err_cnt !== 0) begin failed++; $display("FAIL wr_ack: got %0d acks %0d err expected 1 0", ack_cnt, err_cnt); end
    tests++; if (ack_dat.size() != 1 || ack_dat[0] !== 16'h0) begin failed++; $display("FAIL wr_dat: got size %0d expected one zero", ack_dat.size()); end
    tests++; if (ack_ce !== 4'b1011 || ce_after_ack !== 4'hF) begin failed++; $display("FAIL wr_ce: got %b/%b expected 1011/1111", ack_ce, ce_after_ack); end
  endtask

  task automatic test_write_timeout();
    clear_mon();
    ry = 1'b0; ry_tmo = 8'd20;
    exp_we_ce = 4'b1110; exp_we_dat = 16'h1234; exp_we_addr = 24'h000040;
    drive_req(1'b1, 2'd0, 24'h000040, 16'h1234);
    req_stb = 1'b0;
    repeat (70) @(negedge clk);
    tests++; if (ack_cnt !== 1 || err_cnt !== 1) begin failed++; $display("FAIL tmo_ack: got %0d acks %0d err expected 1 1", ack_cnt, err_cnt); end
    tests++; if (ack_cyc - rywait_cyc !== 20) begin failed++; $display("FAIL tmo_delay: got %0d expected 20", ack_cyc - rywait_cyc); end
    tests++; if (we_bad !== 0) begin failed++; $display("FAIL tmo_pins: got %0d bad cycles expected 0", we_bad); end
    ry = 1'b1; ry_tmo = 8'd50;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_page_burst();
    logic [15:0] exp [4];
    exp[0] = 16'h5A4A; exp[1] = 16'h5A4B; exp[2] = 16'h5A48; exp[3] = 16'h5A49;
    clear_mon();
    pgen = 1'b1;
    for (int i = 0; i < 4; i++) drive_req(1'b0, 2'd1, 24'h000010 + 24'(i), 16'h0);
    req_stb = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (oe_low_cnt !== 12 || oe_runs !== 1) begin failed++; $display("FAIL pg_oe: got %0d cycles %0d runs expected 12 1", oe_low_cnt, oe_runs); end
    tests++; if (ce_low_cnt !== 12 || ce_runs !== 1 || ce_or !== 4'b0010) begin failed++; $display("FAIL pg_ce: got %0d %0d %b expected 12 1 0010", ce_low_cnt, ce_runs, ce_or); end
    tests++; if (ack_cnt !== 4 || err_cnt !== 0) begin failed++; $display("FAIL pg_acks: got %0d %0d expected 4 0", ack_cnt, err_cnt); end
    if (ack_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (ack_dat[i] !== exp[i]) begin failed++; $display("FAIL pg_dat%0d: got %h expected %h", i, ack_dat[i], exp[i]); end
      end
    end else begin
      tests++; failed++; $display("FAIL pg_dat_count: got %0d expected 4", ack_dat.size());
    end
    pgen = 1'b0;
  endtask

  task automatic test_chip_switch();
    clear_mon();
    drive_req(1'b0, 2'd0, 24'h000005, 16'h0);
    drive_req(1'b0, 2'd2, 24'h000005, 16'h0);
    req_stb = 1'b0;
    repeat (40) @(negedge clk);
    tests++; if (ce_overlap !== 0 || ce_runs !== 2 || ce_or !== 4'b0101) begin failed++; $display("FAIL sw_ce: got %0d %0d %b expected 0 2 0101", ce_overlap, ce_runs, ce_or); end
    tests++; if (ack_cnt !== 2 || ack_dat.size() != 2) begin failed++; $display("FAIL sw_acks: got %0d expected 2", ack_cnt); end
    else if (ack_dat[0] !== 16'h5A5F || ack_dat[1] !== 16'h5A5F) begin failed++; $display("FAIL sw_dat: got %h %h expected 5a5f 5a5f", ack_dat[0], ack_dat[1]); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    ry = 1'b0; ry_tmo = 8'd100;
    exp_we_ce = 4'b1110;
    for (int i = 0; i < 4; i++) drive_req(1'b1, 2'd0, 24'(i), 16'hA000 + 16'(i));
    tests++; if (req_stall !== 1'b1) begin failed++; $display("FAIL bp_stall: got %b expected 1", req_stall); end
    drive_req(1'b1, 2'd0, 24'h000004, 16'hA004);
    req_stb = 1'b0;
    repeat (10) @(negedge clk);
    ry = 1'b1;
    repeat (150) @(negedge clk);
    tests++; if (ack_cnt !== 4 || err_cnt !== 0) begin failed++; $display("FAIL bp_acks: got %0d acks %0d err expected 4 0", ack_cnt, err_cnt); end
    tests++; if (req_stall !== 1'b0) begin failed++; $display("FAIL bp_drain: got %b expected 0", req_stall); end
    ry_tmo = 8'd50;
  endtask

  task automatic test_reset_mid_read();
    clear_mon();
    drive_req(1'b0, 2'd3, 24'h000020, 16'h0);
    req_stb = 1'b0;
    for (int c = 0; c < 40 && oe_low_cnt < 4; c++) @(negedge clk);
    tests++; if (oe_low_cnt < 4 || ack_cnt != 0) begin failed++; $display("FAIL rr_reach_read: got %0d oe cycles %0d acks expected 4 0", oe_low_cnt, ack_cnt); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({ce, we_n, oe_n, data_oe} !== 7'b1111_110) begin failed++; $display("FAIL rr_ctl: got %b expected 1111110", {ce, we_n, oe_n, data_oe}); end
    tests++; if (nor_addr !== 24'h0 || nor_dout !== 16'h0) begin failed++; $display("FAIL rr_bus: got %h %h expected 0 0", nor_addr, nor_dout); end
    tests++; if ({ack, err, dat_o, req_stall} !== 19'h0) begin failed++; $display("FAIL rr_resp: got %h expected 0", {ack, err, dat_o, req_stall}); end
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    repeat (30) @(negedge clk);
    tests++; if (ack_cnt !== 0 || ce_low_cnt !== 0) begin failed++; $display("FAIL rr_no_ack: got %0d acks %0d ce cycles expected 0 0", ack_cnt, ce_low_cnt); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_write();
    test_write_timeout();
    test_page_burst();
    test_chip_switch();
    test_backpressure();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
